// File: rtl/dmem_run_pkg.sv
// Shared types and default widths for the run controller / DataMem arbiter slice.
package dmem_run_pkg;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_START,
    RS_RUN,
    RS_DONE
  } run_state_e;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CYC_W     = 32;
  localparam int DEF_START_CYC = 2;
  localparam int DEF_MAX_CYC   = 0;

endpackage

// File: rtl/dmem_run_ctrl_if.sv
// Host, core and DataMem signal bundle seen by the run controller.
interface dmem_run_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CYC_W  = 32
);

  logic              host_go;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic              core_halt;
  logic              core_rd;
  logic              core_wr;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_start;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              done;
  logic              timeout;
  logic [CYC_W-1:0]  cycle_ct;

  // Controller side
  modport slave (
    input  host_go, host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    input  core_halt, core_rd, core_wr, core_addr, core_wdata,
    output core_start,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, done, timeout, cycle_ct
  );

  // Host / harness side, which also models DataMem and the core
  modport master (
    output host_go, host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    output core_halt, core_rd, core_wr, core_addr, core_wdata,
    input  core_start,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, done, timeout, cycle_ct
  );

endinterface

// File: rtl/run_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear and a watchdog compare.
module run_cycle_counter #(
  parameter int CYC_W   = 32,
  parameter int MAX_CYC = 0
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CYC_W-1:0] count,
  output logic             hit
);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CYC_W'(1);
    end
  end

  // A zero limit disables the watchdog entirely
  assign hit = (MAX_CYC != 0) && (count == CYC_W'(MAX_CYC));

endmodule

// File: rtl/dmem_run_ctrl.sv
// Run sequencer for the 9-bit core: start pulse, cycle counting, watchdog,
// and host/core arbitration of the single DataMem port.
module dmem_run_ctrl
  import dmem_run_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CYC_W     = DEF_CYC_W,
  parameter int START_CYC = DEF_START_CYC,
  parameter int MAX_CYC   = DEF_MAX_CYC
) (
  input logic            CLK,
  input logic            reset_n,
  dmem_run_ctrl_if.slave bus
);

  localparam int SC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  run_state_e        state;
  logic [SC_W-1:0]   start_cnt;
  logic              core_start_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              host_rvalid_q;
  logic              host_owns;
  logic              start_entry;
  logic              run_step;
  logic              wd_hit;
  logic              host_rd_gnt;
  logic [CYC_W-1:0]  cycle_ct;
  logic              mem_rd_c;
  logic              mem_wr_c;
  logic              host_gnt_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign host_owns   = (state == RS_IDLE) || (state == RS_DONE);
  assign start_entry = host_owns && bus.host_go && !bus.host_req;
  assign run_step    = (state == RS_RUN) && !bus.core_halt && !wd_hit;
  assign host_rd_gnt = host_owns && bus.host_req && !bus.host_we;

  run_cycle_counter #(
    .CYC_W   (CYC_W),
    .MAX_CYC (MAX_CYC)
  ) u_counter (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clear   (start_entry),
    .enable  (run_step),
    .count   (cycle_ct),
    .hit     (wd_hit)
  );

  // Halt is tested before the watchdog so a halt on the limit cycle is a clean finish
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RS_IDLE;
      start_cnt    <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      unique case (state)
        RS_IDLE, RS_DONE: begin
          if (start_entry) begin
            state        <= RS_START;
            start_cnt    <= SC_W'(START_CYC - 1);
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
          end
        end
        RS_START: begin
          if (start_cnt == '0) begin
            state        <= RS_RUN;
            core_start_q <= 1'b0;
          end else begin
            start_cnt <= start_cnt - SC_W'(1);
          end
        end
        RS_RUN: begin
          if (bus.core_halt) begin
            state  <= RS_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (wd_hit) begin
            state     <= RS_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: state <= RS_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_rvalid_q <= host_rd_gnt;
      if (host_rd_gnt) host_rdata_q <= bus.mem_rdata;
    end
  end

  // Enables are gated by reset_n so a reset mid-run drops DataMem strobes immediately
  always_comb begin
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    host_gnt_c  = 1'b0;
    mem_addr_c  = bus.host_addr;
    mem_wdata_c = bus.host_wdata;
    if (reset_n) begin
      unique case (state)
        RS_RUN: begin
          mem_rd_c    = bus.core_rd;
          mem_wr_c    = bus.core_wr;
          mem_addr_c  = bus.core_addr;
          mem_wdata_c = bus.core_wdata;
        end
        RS_IDLE, RS_DONE: begin
          host_gnt_c = bus.host_req;
          mem_rd_c   = bus.host_req && !bus.host_we;
          mem_wr_c   = bus.host_req && bus.host_we;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.host_gnt    = host_gnt_c;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.core_start  = core_start_q;
  assign bus.mem_rd      = mem_rd_c;
  assign bus.mem_wr      = mem_wr_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_ct    = cycle_ct;

endmodule

// File: tb/tb_dmem_run_ctrl.sv
// Scoreboard bench: two controllers (watchdog off / limit 20) share one random stimulus stream.
module tb_dmem_run_ctrl;

  localparam int START_CYC = 2;
  localparam int WD_MAX    = 20;

  typedef struct {
    int unsigned ct;
    bit          to;
  } run_exp_t;

  logic CLK     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   fails   = 0;

  logic [7:0] dmem_m  [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_exp_q [$];
  run_exp_t   main_exp_q [$];
  run_exp_t   wd_exp_q [$];
  logic       main_done_prev = 1'b0;
  logic       wd_done_prev   = 1'b0;

  always #5 CLK = ~CLK;

  dmem_run_ctrl_if #(.ADDR_W(8), .DATA_W(8), .CYC_W(32)) ifm ();
  dmem_run_ctrl_if #(.ADDR_W(8), .DATA_W(8), .CYC_W(32)) ifw ();

  dmem_run_ctrl #(.ADDR_W(8), .DATA_W(8), .CYC_W(32), .START_CYC(START_CYC), .MAX_CYC(0))
    dut_main (.CLK(CLK), .reset_n(reset_n), .bus(ifm));
  dmem_run_ctrl #(.ADDR_W(8), .DATA_W(8), .CYC_W(32), .START_CYC(START_CYC), .MAX_CYC(WD_MAX))
    dut_wd (.CLK(CLK), .reset_n(reset_n), .bus(ifw));

  assign ifw.host_go    = ifm.host_go;
  assign ifw.host_req   = ifm.host_req;
  assign ifw.host_we    = ifm.host_we;
  assign ifw.host_addr  = ifm.host_addr;
  assign ifw.host_wdata = ifm.host_wdata;
  assign ifw.core_halt  = ifm.core_halt;
  assign ifw.core_rd    = ifm.core_rd;
  assign ifw.core_wr    = ifm.core_wr;
  assign ifw.core_addr  = ifm.core_addr;
  assign ifw.core_wdata = ifm.core_wdata;
  assign ifw.mem_rdata  = '0;

  // DataMem model for the main controller: combinational read, posedge write
  assign ifm.mem_rdata = dmem_m[ifm.mem_addr];
  always @(posedge CLK) begin
    if (ifm.mem_wr) dmem_m[ifm.mem_addr] <= ifm.mem_wdata;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Run outcome straight from the rules: halt after n cycles unless the limit is passed first
  function automatic run_exp_t predict(input int n, input int max_cyc);
    run_exp_t r;
    if (max_cyc != 0 && n > max_cyc) begin
      r.ct = max_cyc;
      r.to = 1'b1;
    end else begin
      r.ct = n;
      r.to = 1'b0;
    end
    return r;
  endfunction

  always @(negedge CLK) begin
    logic [7:0] exp_rd;
    run_exp_t   e;
    if (reset_n) begin
      if (ifm.host_rvalid) begin
        if (rd_exp_q.size() == 0) check_output("rvalid_unexpected", ifm.host_rvalid, 1'b0);
        else begin
          exp_rd = rd_exp_q.pop_front();
          check_output("host_rdata", ifm.host_rdata, exp_rd);
        end
      end
      if (ifm.done && !main_done_prev) begin
        if (main_exp_q.size() == 0) check_output("main_done_unexpected", ifm.done, 1'b0);
        else begin
          e = main_exp_q.pop_front();
          check_output("main_cycle_ct", ifm.cycle_ct, e.ct);
          check_output("main_timeout", ifm.timeout, e.to);
        end
      end
      if (ifw.done && !wd_done_prev) begin
        if (wd_exp_q.size() == 0) check_output("wd_done_unexpected", ifw.done, 1'b0);
        else begin
          e = wd_exp_q.pop_front();
          check_output("wd_cycle_ct", ifw.cycle_ct, e.ct);
          check_output("wd_timeout", ifw.timeout, e.to);
        end
      end
    end
    main_done_prev = ifm.done;
    wd_done_prev   = ifw.done;
  end

  task automatic host_access(input bit we, input logic [7:0] a, input logic [7:0] d);
    @(posedge CLK); #1;
    ifm.host_req   = 1'b1;
    ifm.host_we    = we;
    ifm.host_addr  = a;
    ifm.host_wdata = d;
    @(negedge CLK);
    check_output("host_gnt", ifm.host_gnt, 1'b1);
    check_output(we ? "host_mem_wr" : "host_mem_rd", we ? ifm.mem_wr : ifm.mem_rd, 1'b1);
    if (we) ref_mem[a] = d;
    else rd_exp_q.push_back(ref_mem[a]);
    @(posedge CLK); #1;
    ifm.host_req = 1'b0;
    @(negedge CLK);
    check_output("host_rvalid_timing", ifm.host_rvalid, !we);
  endtask

  task automatic random_host(input int count);
    for (int i = 0; i < count; i++) host_access(1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic run_program(input int n, input bit go_with_req);
    int hi;
    main_exp_q.push_back(predict(n, 0));
    wd_exp_q.push_back(predict(n, WD_MAX));
    @(posedge CLK); #1;
    ifm.host_go = 1'b1;
    if (go_with_req) begin
      ifm.host_req   = 1'b1;
      ifm.host_we    = 1'b1;
      ifm.host_addr  = 8'($urandom);
      ifm.host_wdata = 8'($urandom);
      @(negedge CLK);
      check_output("go_req_gnt", ifm.host_gnt, 1'b1);
      ref_mem[ifm.host_addr] = ifm.host_wdata;
      @(posedge CLK); #1;
      ifm.host_req = 1'b0;
      @(negedge CLK);
      check_output("go_ignored_busy", ifm.busy, 1'b0);
      check_output("go_ignored_done", ifm.done, 1'b1);
      @(posedge CLK); #1;
    end else begin
      @(posedge CLK); #1;
    end
    ifm.host_go = 1'b0;
    @(negedge CLK);
    check_output("start_cycle_ct", ifm.cycle_ct, 0);
    check_output("start_done", ifm.done, 1'b0);
    check_output("start_busy", ifm.busy, 1'b1);
    check_output("start_mem_wr", ifm.mem_wr, 1'b0);
    hi = 0;
    while (ifm.core_start && hi < 8) begin
      hi++;
      @(negedge CLK);
    end
    check_output("core_start_width", hi, START_CYC);
    for (int i = 0; i < n; i++) begin
      ifm.core_rd    = 1'($urandom);
      ifm.core_wr    = 1'($urandom);
      ifm.core_addr  = 8'($urandom);
      ifm.core_wdata = 8'($urandom);
      ifm.host_req   = 1'($urandom);
      ifm.host_we    = 1'($urandom);
      ifm.host_addr  = 8'($urandom);
      #1;
      check_output("run_host_gnt", ifm.host_gnt, 1'b0);
      check_output("run_mem_rd", ifm.mem_rd, ifm.core_rd);
      check_output("run_mem_wr", ifm.mem_wr, ifm.core_wr);
      check_output("run_mem_addr", ifm.mem_addr, ifm.core_addr);
      check_output("run_mem_wdata", ifm.mem_wdata, ifm.core_wdata);
      if (ifm.core_wr) ref_mem[ifm.core_addr] = ifm.core_wdata;
      @(negedge CLK);
    end
    ifm.core_halt = 1'b1;
    ifm.core_rd   = 1'b0;
    ifm.core_wr   = 1'b0;
    ifm.host_req  = 1'b0;
    @(posedge CLK); #1;
    ifm.core_halt = 1'b0;
    hi = 0;
    do begin
      @(negedge CLK);
      hi++;
    end while (!ifm.done && hi < 10);
    check_output("run_done", ifm.done, 1'b1);
  endtask

  task automatic reset_mid_run();
    @(posedge CLK); #1;
    ifm.host_go = 1'b1;
    @(posedge CLK); #1;
    ifm.host_go = 1'b0;
    repeat (START_CYC + 4) @(negedge CLK);
    ifm.core_wr    = 1'b1;
    ifm.core_addr  = 8'($urandom);
    ifm.core_wdata = 8'($urandom);
    #1;
    check_output("pre_reset_mem_wr", ifm.mem_wr, 1'b1);
    check_output("pre_reset_cycle_ct", ifm.cycle_ct, 3);
    reset_n = 1'b0;
    #1;
    check_output("reset_mem_wr", ifm.mem_wr, 1'b0);
    check_output("reset_wd_mem_wr", ifw.mem_wr, 1'b0);
    check_output("reset_busy", ifm.busy, 1'b0);
    check_output("reset_done", ifm.done, 1'b0);
    check_output("reset_cycle_ct", ifm.cycle_ct, 0);
    check_output("reset_core_start", ifm.core_start, 1'b0);
    ifm.core_wr = 1'b0;
    @(posedge CLK); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem_m[i]  = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ifm.host_go = 1'b0;  ifm.host_req = 1'b0;  ifm.host_we = 1'b0;
    ifm.host_addr = '0;  ifm.host_wdata = '0;
    ifm.core_halt = 1'b0; ifm.core_rd = 1'b0;  ifm.core_wr = 1'b0;
    ifm.core_addr = '0;  ifm.core_wdata = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_output("init_busy", ifm.busy, 1'b0);
    check_output("init_done", ifm.done, 1'b0);
    check_output("init_timeout", ifm.timeout, 1'b0);
    check_output("init_core_start", ifm.core_start, 1'b0);
    check_output("init_cycle_ct", ifm.cycle_ct, 0);
    check_output("init_host_rvalid", ifm.host_rvalid, 1'b0);
    check_output("init_host_rdata", ifm.host_rdata, 8'h00);
    @(posedge CLK); #1;
    reset_n = 1'b1;

    host_access(1'b1, 8'h10, 8'hA5);
    host_access(1'b0, 8'h10, 8'h00);
    random_host(8);
    run_program(37, 1'b0);
    host_access(1'b0, 8'h10, 8'h00);
    random_host(4);
    run_program(12, 1'b1);
    for (int r = 0; r < 6; r++) begin
      run_program(int'($urandom_range(1, 30)), 1'b0);
      random_host(3);
    end
    run_program(WD_MAX, 1'b0);
    run_program(WD_MAX + 5, 1'b0);
    random_host(3);
    reset_mid_run();
    random_host(4);
    repeat (3) @(negedge CLK);
    check_output("rd_queue_drained", rd_exp_q.size(), 0);
    check_output("main_queue_drained", main_exp_q.size(), 0);
    check_output("wd_queue_drained", wd_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
